// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional busy scoreboard is enabled with REGFILE_SCOREBOARD_EN.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    // LSB of port `port` inside a packed vector of `w`-bit lanes
    function automatic int lsb(input int port, input int w);
        return port * w;
    endfunction

    function automatic logic is_zero_reg(
        input int zero_reg,
        input logic is_addr0
    );
        return (zero_reg != 0) && is_addr0;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write bus of the multi-port register file.
// rsv_en/rsv_num/rd_busy exist only with REGFILE_SCOREBOARD_EN.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1
);

    logic                     ready;
    logic [NREAD*ADDR_W-1:0]  rd_num;
    logic [NREAD*DATA_W-1:0]  rd_data;
    logic [NWRITE-1:0]        wr_en;
    logic [NWRITE*ADDR_W-1:0] wr_num;
    logic [NWRITE*DATA_W-1:0] wr_data;
`ifdef REGFILE_SCOREBOARD_EN
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_num;
    logic [NREAD-1:0]         rd_busy;
`endif

    modport master (
        input  ready,
        input  rd_data,
        output rd_num,
        output wr_en,
        output wr_num,
`ifdef REGFILE_SCOREBOARD_EN
        output rsv_en,
        output rsv_num,
        input  rd_busy,
`endif
        output wr_data
    );

    modport slave (
        output ready,
        output rd_data,
        input  rd_num,
        input  wr_en,
        input  wr_num,
`ifdef REGFILE_SCOREBOARD_EN
        input  rsv_en,
        input  rsv_num,
        output rd_busy,
`endif
        input  wr_data
    );

endinterface

// File: rtl/regfile_bypass.sv
// Per-read-port mux: same-cycle write bypass over the array value,
// with zero-register and clear-sweep overrides.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_run,
    input  logic [ADDR_W-1:0]        i_rd_num,
    input  logic [NWRITE-1:0]        i_wr_en,
    input  logic [NWRITE*ADDR_W-1:0] i_wr_num,
    input  logic [NWRITE*DATA_W-1:0] i_wr_data,
    input  logic [DATA_W-1:0]        i_mem_data,
    output logic [DATA_W-1:0]        o_rd_data
);

    logic [DATA_W-1:0] w_data;
    logic              w_force0;

    assign w_force0 = !i_run
                    || is_zero_reg(ZERO_REG, i_rd_num == '0);

    // Ascending scan: the highest-numbered matching port is applied last
    always_comb begin
        w_data = i_mem_data;
        for (int p = 0; p < NWRITE; p++) begin
            if (i_wr_en[p]
                && i_wr_num[lsb(p, ADDR_W) +: ADDR_W] == i_rd_num) begin
                w_data = i_wr_data[lsb(p, DATA_W) +: DATA_W];
            end
        end
    end

    assign o_rd_data = w_force0 ? '0 : w_data;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with reset clear sweep.
// Define REGFILE_SCOREBOARD_EN to add the reserve/busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_e         r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_run;

    assign w_run     = (r_state == RUN);
    assign bus.ready = r_ready;

    // Clear sweep and port writes share one process so they never overlap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            unique case (r_state)
                CLEAR: begin
                    r_mem[r_clr_idx] <= '0;
                    r_clr_idx        <= r_clr_idx + 1'b1;
                    if (&r_clr_idx) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    for (int p = 0; p < NWRITE; p++) begin
                        if (bus.wr_en[p]
                            && !is_zero_reg(ZERO_REG,
                                bus.wr_num[lsb(p, ADDR_W) +: ADDR_W] == '0)) begin
                            r_mem[bus.wr_num[lsb(p, ADDR_W) +: ADDR_W]]
                                <= bus.wr_data[lsb(p, DATA_W) +: DATA_W];
                        end
                    end
                end
            endcase
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] r_busy;

    // Reserve is applied after the write clear, so it wins on a collision
    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            r_busy <= '0;
        end else begin
            for (int p = 0; p < NWRITE; p++) begin
                if (bus.wr_en[p]) begin
                    r_busy[bus.wr_num[lsb(p, ADDR_W) +: ADDR_W]] <= 1'b0;
                end
            end
            if (bus.rsv_en
                && !is_zero_reg(ZERO_REG, bus.rsv_num == '0)) begin
                r_busy[bus.rsv_num] <= 1'b1;
            end
        end
    end
`endif

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_num;
        logic [DATA_W-1:0] w_rd;

        assign w_num = bus.rd_num[lsb(i, ADDR_W) +: ADDR_W];

        regfile_bypass #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NWRITE   (NWRITE),
            .ZERO_REG (ZERO_REG)
        ) u_byp (
            .i_run      (w_run),
            .i_rd_num   (w_num),
            .i_wr_en    (bus.wr_en),
            .i_wr_num   (bus.wr_num),
            .i_wr_data  (bus.wr_data),
            .i_mem_data (r_mem[w_num]),
            .o_rd_data  (w_rd)
        );

        assign bus.rd_data[lsb(i, DATA_W) +: DATA_W] = w_rd;

`ifdef REGFILE_SCOREBOARD_EN
        assign bus.rd_busy[i] = r_busy[w_num];
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 32x32 2R/2W instance and a 64x64 4R/1W one.
// Scoreboard sequence runs only when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

    logic clk;
    logic rst;

    int total;
    int bad;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2)) busA ();
    regfile_mp_if #(.DATA_W(64), .ADDR_W(6), .NREAD(4), .NWRITE(1)) busB ();

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2), .ZERO_REG(1)
    ) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    regfile_mp #(
        .DATA_W(64), .ADDR_W(6), .NREAD(4), .NWRITE(1), .ZERO_REG(1)
    ) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  wn0;
        logic [31:0] wd0;
        logic [4:0]  wn1;
        logic [31:0] wd1;
        logic [4:0]  rn0;
        logic [4:0]  rn1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cnt_ready_a(output int k);
        k = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (busA.ready) begin
                k = n;
                break;
            end
        end
    endtask

    initial begin
        int kA;
        int kB;
        logic [5:0]  baddr [4];
        logic [63:0] bdata [4];

        total = 0;
        bad   = 0;

        tv[0]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,
                   5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
        tv[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,
                   5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tv[2]  = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,
                   5'd7,  5'd5,  32'h22,       32'hDEADBEEF};
        tv[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,
                   5'd7,  5'd7,  32'h22,       32'h22};
        tv[4]  = '{2'b11, 5'd3,  32'h33,       5'd0,  32'hFFFFFFFF,
                   5'd0,  5'd3,  32'h0,        32'h33};
        tv[5]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,
                   5'd0,  5'd3,  32'h0,        32'h33};
        tv[6]  = '{2'b11, 5'd31, 32'h12345678, 5'd1,  32'hCAFEF00D,
                   5'd31, 5'd1,  32'h12345678, 32'hCAFEF00D};
        tv[7]  = '{2'b01, 5'd7,  32'h77,       5'd0,  32'h0,
                   5'd7,  5'd31, 32'h77,       32'h12345678};
        tv[8]  = '{2'b01, 5'd12, 32'hA,        5'd12, 32'hB,
                   5'd12, 5'd1,  32'hA,        32'hCAFEF00D};
        tv[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,
                   5'd12, 5'd7,  32'hA,        32'h77};
        tv[10] = '{2'b11, 5'd7,  32'h88,       5'd7,  32'h99,
                   5'd7,  5'd1,  32'h99,       32'hCAFEF00D};
        tv[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,
                   5'd7,  5'd0,  32'h99,       32'h0};

        rst          = 1'b1;
        busA.rd_num  = '0;
        busA.wr_en   = '0;
        busA.wr_num  = '0;
        busA.wr_data = '0;
        busB.rd_num  = '0;
        busB.wr_en   = '0;
        busB.wr_num  = '0;
        busB.wr_data = '0;
`ifdef REGFILE_SCOREBOARD_EN
        busA.rsv_en  = 1'b0;
        busA.rsv_num = '0;
        busB.rsv_en  = 1'b0;
        busB.rsv_num = '0;
`endif

        // Initial sweep: 3 reset cycles, then both files count to ready
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readyA", 64'(busA.ready), 64'd0);
        chk("rst_rdA", 64'(busA.rd_data), 64'd0);
        chk("rst_readyB", 64'(busB.ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        kA = 0;
        kB = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (busA.ready && kA == 0) kA = n;
            if (busB.ready && kB == 0) kB = n;
            if (kA != 0 && kB != 0) break;
        end
        chk("sweep_A_cycles", 64'(kA), 64'd32);
        chk("sweep_B_cycles", 64'(kB), 64'd64);

        // Reset again, then re-reset at clr_idx=10 while hammering writes
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busA.wr_en = 2'b11;
        for (int n = 0; n < 10; n++) begin
            busA.wr_num  = {5'(31 - n), 5'(n + 1)};
            busA.wr_data = {32'h5A5A5A5A, 32'hA5A5A5A5};
            busA.rd_num  = {5'(31 - n), 5'(n + 1)};
            #1;
            if (n == 4) begin
                chk("clear_rd0_bypass", 64'(busA.rd_data[31:0]), 64'd0);
                chk("clear_rd1_bypass", 64'(busA.rd_data[63:32]), 64'd0);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        kA = 0;
        for (int n = 1; n <= 100; n++) begin
            busA.wr_num  = {5'(31 - (n % 32)), 5'(n % 32)};
            @(posedge clk);
            #1;
            if (busA.ready) begin
                kA = n;
                break;
            end
        end
        busA.wr_en = 2'b00;
        chk("midsweep_A_cycles", 64'(kA), 64'd32);

        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            busA.rd_num = {5'(a + 16), 5'(a)};
            #1;
            chk($sformatf("zero_addr%0d", a),
                64'(busA.rd_data[31:0]), 64'd0);
            chk($sformatf("zero_addr%0d", a + 16),
                64'(busA.rd_data[63:32]), 64'd0);
        end

        // Table of RUN vectors: drive, check combinational reads, commit
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            busA.wr_en   = tv[i].en;
            busA.wr_num  = {tv[i].wn1, tv[i].wn0};
            busA.wr_data = {tv[i].wd1, tv[i].wd0};
            busA.rd_num  = {tv[i].rn1, tv[i].rn0};
            #1;
            chk($sformatf("vec%0d_p0", i),
                64'(busA.rd_data[31:0]), 64'(tv[i].e0));
            chk($sformatf("vec%0d_p1", i),
                64'(busA.rd_data[63:32]), 64'(tv[i].e1));
        end
        @(negedge clk);
        busA.wr_en = 2'b00;

`ifdef REGFILE_SCOREBOARD_EN
        busA.rd_num  = {5'd0, 5'd9};
        busA.rsv_en  = 1'b1;
        busA.rsv_num = 5'd9;
        #1;
        chk("busy_before", 64'(busA.rd_busy[0]), 64'd0);
        @(negedge clk);
        busA.rsv_en = 1'b0;
        #1;
        chk("busy_set", 64'(busA.rd_busy[0]), 64'd1);
        busA.wr_en   = 2'b01;
        busA.wr_num  = {5'd0, 5'd9};
        busA.wr_data = {32'h0, 32'h9};
        #1;
        chk("busy_no_bypass", 64'(busA.rd_busy[0]), 64'd1);
        @(negedge clk);
        busA.wr_en = 2'b00;
        #1;
        chk("busy_cleared", 64'(busA.rd_busy[0]), 64'd0);
        busA.rsv_en = 1'b1;
        busA.wr_en  = 2'b01;
        @(negedge clk);
        busA.rsv_en = 1'b0;
        busA.wr_en  = 2'b00;
        #1;
        chk("busy_rsv_wins", 64'(busA.rd_busy[0]), 64'd1);
        busA.rsv_en  = 1'b1;
        busA.rsv_num = 5'd0;
        @(negedge clk);
        busA.rsv_en = 1'b0;
        #1;
        chk("busy_zero_reg", 64'(busA.rd_busy[1]), 64'd0);
`endif

        // Reset out of RUN: reads forced to 0 and the array swept
        @(negedge clk);
        busA.rd_num = {5'd31, 5'd7};
        #1;
        chk("pre_rst_rd7", 64'(busA.rd_data[31:0]), 64'h99);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("run_rst_ready", 64'(busA.ready), 64'd0);
        chk("run_rst_rd7", 64'(busA.rd_data[31:0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_ready_a(kA);
        chk("run_rst_A_cycles", 64'(kA), 64'd32);
        chk("post_sweep_rd7", 64'(busA.rd_data[31:0]), 64'd0);
        chk("post_sweep_rd31", 64'(busA.rd_data[63:32]), 64'd0);

        // Wide instance: four writes, then four parallel reads
        kB = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (busB.ready) begin
                kB = n;
                break;
            end
        end
        chk("B_ready", 64'(busB.ready), 64'd1);
        baddr[0] = 6'd10;
        baddr[1] = 6'd63;
        baddr[2] = 6'd33;
        baddr[3] = 6'd1;
        bdata[0] = 64'h1111_2222_3333_4444;
        bdata[1] = 64'hFEDC_BA98_7654_3210;
        bdata[2] = 64'h0123_4567_89AB_CDEF;
        bdata[3] = 64'h8000_0000_0000_0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            busB.wr_en   = 1'b1;
            busB.wr_num  = baddr[i];
            busB.wr_data = bdata[i];
        end
        @(negedge clk);
        busB.wr_en  = 1'b0;
        busB.rd_num = {baddr[0], baddr[2], baddr[1], baddr[3]};
        #1;
        chk("B_port0", busB.rd_data[63:0],    bdata[3]);
        chk("B_port1", busB.rd_data[127:64],  bdata[1]);
        chk("B_port2", busB.rd_data[191:128], bdata[2]);
        chk("B_port3", busB.rd_data[255:192], bdata[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, successor to the single-write/dual-read regfile.
- Configurable data width, depth, read-port count and write-port count.
- Same-cycle write-to-read bypass.
- Reset-triggered clear sweep with a ready flag.
- Feeds the decode/operand-fetch stage of the superscalar MIPS core and takes writebacks from all retiring lanes.

Parameters:
DATA_W, 32, bits per register
ADDR_W, 5, address bits; DEPTH = 2**ADDR_W
NREAD, 2, number of read ports
NWRITE, 1, number of write ports
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes dropped, reads 0)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
ready  output  1  high when the clear sweep is done and the file accepts writes
rd_num  input  NREAD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  output  NREAD*DATA_W  read data, combinational
wr_en  input  NWRITE  per-port write enable
wr_num  input  NWRITE*ADDR_W  write addresses
wr_data  input  NWRITE*DATA_W  write data
rsv_en  input  1  (REGFILE_SCOREBOARD_EN only) reserve a destination
rsv_num  input  ADDR_W  (REGFILE_SCOREBOARD_EN only) register to reserve
rd_busy  output  NREAD  (REGFILE_SCOREBOARD_EN only) busy bit of each read address

Behaviour:
- Single clock domain; one clock (clk); reset synchronous, active-high (rst).
- FSM states: CLEAR and RUN.
- Reset:
  - rst high at a posedge forces state=CLEAR, clr_idx=0, ready=0.
  - Reset mid-sweep or mid-RUN restarts the sweep from index 0.
- CLEAR:
  - Each posedge with rst low writes 0 to mem[clr_idx], then clr_idx++.
  - When clr_idx==DEPTH-1 is cleared: state=RUN, ready=1.
  - ready rises exactly DEPTH posedges after the last rst-high posedge.
  - In CLEAR, all wr_en are ignored and all rd_data read 0.
- RUN write: on posedge, for each port p with wr_en[p]=1, mem[wr_num[p]] <= wr_data[p].
  - Same address on multiple ports: the highest-numbered port wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- RUN read: rd_data[i] is combinational.
  - Address 0 with ZERO_REG=1 reads 0.
  - Otherwise, if any enabled write port targets rd_num[i] this cycle, return its wr_data (highest port wins) as a bypass.
  - Otherwise return mem[rd_num[i]].
  - Write-then-read in the same cycle therefore needs no negedge write.
- Latency: read 0 cycles; write visible through the array from the next cycle, and through the bypass in the same cycle.
- Outputs after reset: ready=0, rd_data=0, rd_busy=0.

Optional Feature:
REGFILE_SCOREBOARD_EN
- Defined:
  - Adds rsv_en, rsv_num, rd_busy and a DEPTH-bit busy vector.
  - Reset or CLEAR: all bits 0.
  - RUN: rsv_en sets busy[rsv_num]; a write to address a clears busy[a].
  - Reserve and write to the same register in one cycle: the reserve wins, so busy stays 1.
  - ZERO_REG=1: busy[0] is never set.
  - rd_busy[i] = busy[rd_num[i]] registered state, with no bypass of the same-cycle clear.
- Undefined: these ports and the busy logic are absent; all other behaviour is identical.

Decomposition:
- Package regfile_pkg:
  - rf_state_e enum {CLEAR, RUN}.
  - Helper functions to slice a packed port vector.
- One sub-module, regfile_bypass: a per-read-port priority mux over the NWRITE write ports plus the array value and the zero/CLEAR override.
- Instantiate regfile_bypass NREAD times with generate.

Test Plan:
- Sweep timing: rst=1 for 3 cycles, then 0 (DEPTH=32) -> ready=0 for 32 posedges, then 1; every address reads 0.
- Reset mid-sweep: rst re-asserted at clr_idx=10 -> ready rises 32 posedges after that reset; wr_en=1 during CLEAR leaves mem at 0.
- Bypass: RUN, write port 0 addr 5 data 0xDEADBEEF, rd_num[0]=5 the same cycle -> rd_data[0]=0xDEADBEEF combinationally and next cycle from the array.
- Write conflict: NWRITE=2, both ports write addr 7 (0x11, 0x22) -> rd of 7 = 0x22; write to addr 0 with 0xFFFFFFFF -> reads 0.
- Scoreboard (macro on): rsv addr 9 -> rd_busy=1 next cycle; write 9 -> busy 0 next cycle; simultaneous rsv 9 + write 9 -> busy stays 1.
- Parameter sweep: DATA_W=64, ADDR_W=6, NREAD=4 -> ready after 64 cycles; 4 independent reads of distinct addresses return the written values.
